// File: rtl/gate_unit_seq.sv
// gate_unit_seq: registered N-bit opcode-selected gate unit with accumulator,
// valid/ready handshake, result flags and a wrapping transaction counter.
module gate_unit_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             clear_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             parity_flag,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             rdy_q;
    logic             accept;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] gate_res;

    // rdy_q holds in_ready low through reset and for the first edge after it
    assign in_ready    = rst_n && rdy_q && (state_q == EMPTY || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == FULL);
    assign result      = result_q;
    assign zero_flag   = zero_q;
    assign parity_flag = parity_q;
    assign op_count    = cnt_q;

    // gate function; the left operand reads the pre-clear accumulator
    always_comb begin
        lhs = acc_mode ? acc_q : a;
        case (op)
            3'd0:    gate_res = ~b;
            3'd1:    gate_res = lhs & b;
            3'd2:    gate_res = lhs | b;
            3'd3:    gate_res = ~(lhs & b);
            3'd4:    gate_res = ~(lhs | b);
            3'd5:    gate_res = lhs ^ b;
            3'd6:    gate_res = ~(lhs ^ b);
            default: gate_res = lhs;
        endcase
    end

    // next state: output stage loads on accept, drains on consume, else holds
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept) begin
            state_d  = FULL;
            result_d = gate_res;
            zero_d   = (gate_res == '0);
            parity_d = ^gate_res;
            cnt_d    = cnt_q + 1'b1;
            acc_d    = acc_mode ? gate_res : acc_q;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
        if (clear_acc) acc_d = '0;
    end

    // single register stage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            result_q <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rdy_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_unit_seq.sv
// tb_gate_unit_seq: directed scoreboard bench for gate_unit_seq (WIDTH=8, CNT_W=16 and CNT_W=4).
module tb_gate_unit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        acc_mode = 1'b0;
    logic        clear_acc = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, zero_flag, parity_flag;
    logic [7:0]  result;
    logic [15:0] op_count;
    logic        rdy4, ov4, z4, p4;
    logic [7:0]  res4;
    logic [3:0]  oc4;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q[$];
    logic        full_m = 1'b0;
    logic        rdy_m = 1'b0;
    logic [7:0]  acc_m = 8'h00;
    logic [7:0]  last_m = 8'h00;
    logic [15:0] cnt_m = 16'h0;

    always #5 clk = ~clk;

    gate_unit_seq #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .clear_acc(clear_acc), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero_flag(zero_flag), .parity_flag(parity_flag), .op_count(op_count)
    );

    gate_unit_seq #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .op(op), .acc_mode(acc_mode), .clear_acc(clear_acc), .a(a), .b(b),
        .out_valid(ov4), .out_ready(out_ready), .result(res4),
        .zero_flag(z4), .parity_flag(p4), .op_count(oc4)
    );

    function automatic logic [7:0] gate(input logic [2:0] o, input logic [7:0] l, input logic [7:0] r);
        case (o)
            3'd0:    return ~r;
            3'd1:    return l & r;
            3'd2:    return l | r;
            3'd3:    return ~(l & r);
            3'd4:    return ~(l | r);
            3'd5:    return l ^ r;
            3'd6:    return ~(l ^ r);
            default: return l;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // drive one cycle, advance the model across the edge, then check all outputs
    task automatic cyc(input logic v, input logic [2:0] o, input logic am, input logic ca,
                       input logic [7:0] aa, input logic [7:0] bb, input logic ordy);
        logic       exp_rdy, acc_t, cons;
        logic [7:0] r;
        in_valid = v; op = o; acc_mode = am; clear_acc = ca; a = aa; b = bb; out_ready = ordy;
        #1;
        exp_rdy = rst_n && rdy_m && (!full_m || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc_t = v && exp_rdy;
        cons  = rst_n && full_m && ordy;
        r     = gate(o, am ? acc_m : aa, bb);
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            full_m = 1'b0; rdy_m = 1'b0; acc_m = 8'h00; last_m = 8'h00; cnt_m = 16'h0;
        end else begin
            rdy_m = 1'b1;
            if (cons) void'(exp_q.pop_front());
            if (acc_t) begin
                exp_q.push_back(r);
                last_m = r;
                cnt_m++;
                full_m = 1'b1;
                if (am) acc_m = r;
            end else if (cons) begin
                full_m = 1'b0;
            end
            if (ca) acc_m = 8'h00;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, full_m});
        if (full_m && exp_q.size() > 0) last_m = exp_q[0];
        chk("result", {24'd0, result}, {24'd0, last_m});
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, last_m == 8'h00});
        chk("parity_flag", {31'd0, parity_flag}, {31'd0, ^last_m});
        chk("op_count", {16'd0, op_count}, {16'd0, cnt_m});
        chk("dut4", {rdy4, ov4, z4, p4, oc4, res4}, {in_ready, full_m, last_m == 8'h00, ^last_m, cnt_m[3:0], last_m});
    endtask

    initial begin
        // reset and first cycle after release: in_ready must still be low
        cyc(1, 3'd1, 0, 0, 8'h12, 8'h34, 1);
        cyc(1, 3'd1, 0, 0, 8'h12, 8'h34, 1);
        rst_n = 1'b1;
        cyc(1, 3'd1, 0, 0, 8'h12, 8'h34, 1);
        chk("post_reset_cnt", {16'd0, op_count}, 32'd0);
        // all eight opcodes back to back
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), 0, 0, 8'hF0, 8'hCC, 1);
        chk("op_count_8", {16'd0, op_count}, 32'd8);
        cyc(0, 3'd0, 0, 0, 8'h00, 8'h00, 1);
        // backpressure
        cyc(1, 3'd5, 0, 0, 8'hFF, 8'hFF, 1);
        chk("bp_zero", {24'd0, result}, 32'h00);
        for (int i = 0; i < 3; i++) cyc(1, 3'd1, 0, 0, 8'hFF, 8'hFF, 0);
        chk("bp_cnt", {16'd0, op_count}, 32'd9);
        cyc(1, 3'd1, 0, 0, 8'hFF, 8'hFF, 1);
        chk("bp_load", {24'd0, result}, 32'hFF);
        // accumulate
        cyc(0, 3'd0, 0, 1, 8'h00, 8'h00, 1);
        cyc(1, 3'd5, 1, 0, 8'h00, 8'h0F, 1);
        chk("acc_0f", {24'd0, result}, 32'h0F);
        cyc(1, 3'd5, 1, 0, 8'h00, 8'hFF, 1);
        chk("acc_f0", {24'd0, result}, 32'hF0);
        cyc(1, 3'd7, 1, 0, 8'h55, 8'h00, 1);
        chk("acc_pass", {24'd0, result}, 32'hF0);
        // clear coincident with write-back
        cyc(1, 3'd2, 1, 1, 8'h00, 8'h01, 1);
        chk("clr_same", {24'd0, result}, 32'hF1);
        cyc(1, 3'd7, 1, 0, 8'hAA, 8'h00, 1);
        chk("clr_after", {24'd0, result}, 32'h00);
        // reset while FULL and stalled
        cyc(1, 3'd2, 1, 0, 8'h00, 8'h3C, 1);
        cyc(1, 3'd3, 0, 0, 8'hAA, 8'h55, 0);
        rst_n = 1'b0;
        cyc(1, 3'd0, 0, 0, 8'h00, 8'h00, 0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", {16'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        cyc(1, 3'd0, 0, 0, 8'h00, 8'h00, 1);
        cyc(1, 3'd7, 1, 0, 8'h99, 8'h00, 1);
        chk("rst_acc", {24'd0, result}, 32'h00);
        // counter wrap on the CNT_W=4 instance
        rst_n = 1'b0;
        cyc(0, 3'd0, 0, 0, 8'h00, 8'h00, 1);
        rst_n = 1'b1;
        cyc(0, 3'd0, 0, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 17; i++)
            cyc(1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0,
                8'($urandom), 8'($urandom), 1);
        chk("wrap4", {28'd0, oc4}, 32'd1);
        chk("wrap16", {16'd0, op_count}, 32'd17);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_unit_seq.md
# gate_unit_seq

Registered, parametrised N-bit logic unit: the multi-bit, opcode-selected, pipelined successor of the team's single-bit basic-gate block. It applies one of eight bitwise gate functions per transaction, optionally folding results into an internal accumulator. It sits between a valid/ready producer and consumer in the lab datapath and registers its result with status flags.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the transaction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  producer offers a transaction
- in_ready  out  1  block can accept this cycle
- op  in  3  gate select (see Operation)
- acc_mode  in  1  1: left operand is the accumulator, and the result is written back to it
- clear_acc  in  1  zero the accumulator (independent of handshake)
- a  in  WIDTH  left operand
- b  in  WIDTH  right operand
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered gate result
- zero_flag  out  1  result == 0, registered with result
- parity_flag  out  1  XOR-reduction of result, registered with result
- op_count  out  CNT_W  number of accepted transactions, wraps modulo 2^CNT_W

## Operation
- Opcodes, bitwise over WIDTH, with L = acc_mode ? acc : a:
  - 0: ~b
  - 1: L&b
  - 2: L|b
  - 3: ~(L&b)
  - 4: ~(L|b)
  - 5: L^b
  - 6: ~(L^b)
  - 7: pass L
- Accept = in_valid && in_ready. Inputs other than clear_acc are sampled only on accept.
- Output FSM:
  - States are EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY --accept--> FULL.
  - FULL --out_ready && !accept--> EMPTY.
  - FULL --out_ready && accept--> FULL, with the new result loaded.
  - FULL --!out_ready--> FULL, with result and flags held bit-stable.
- in_ready = !out_valid || out_ready (combinational; single-entry output stage, full throughput).
- Accumulator (WIDTH bits, internal):
  - On accept with acc_mode=1, acc <= computed result.
  - On accept with acc_mode=0, acc is unchanged.
- clear_acc:
  - Sets acc to 0 at the next edge and takes priority over an acc-mode write-back in the same cycle.
  - That same-cycle transaction still computes with the pre-clear acc value.
  - clear_acc does not affect result, flags, out_valid or op_count.
- op_count increments by 1 on every accept, regardless of opcode or mode.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - out_valid=0, result=0, zero_flag=1, parity_flag=0, acc=0, op_count=0.
  - in_ready is 1 one cycle after reset deasserts. During reset in_ready=0; inputs are ignored.
- Reset mid-operation: a pending FULL result is discarded without handshake, and a transaction offered in the reset cycle is dropped and not counted.
- Latency: accept at edge k → result, flags and out_valid visible after edge k, consumable at edge k+1.
- Throughput: one transaction per cycle while out_ready=1.
- Back-to-back acc-mode transactions each see the accumulator value written by the previous accept (no hazard bubble).
- op_count wraps from 2^CNT_W−1 to 0 without a flag.
- Flags always correspond to the currently held result.

## Test plan
- WIDTH=8, a=8'hF0, b=8'hCC, out_ready=1, op 0..7 on consecutive cycles → result sequence 33, C0, FC, 3F, 03, 3C, C3, F0 one cycle after each accept. zero_flag=0 throughout; parity_flag matches ^result; op_count reaches 8.
- Backpressure:
  - Accept a=8'hFF, b=8'hFF, op=5, then hold out_ready=0 and keep offering op=1 → result=00 and zero_flag=1 held, in_ready=0, op_count stays 1.
  - Raise out_ready → next transaction loads the same cycle, result=FF.
- Accumulate:
  - Pulse clear_acc, then acc_mode=1, op=5 with b=0F, then with b=FF → results 0F then F0.
  - A following op=7 with acc_mode=1 → result F0.
- clear_acc coincident with acc-mode accept (acc=F0, op=2, b=01) → result F1; a following op=7 with acc_mode=1 returns 00.
- Reset mid-stream: drive rst_n low while FULL with out_ready=0 → after the edge, out_valid=0, result=00, zero_flag=1, op_count=0, acc=0.
- Counter wrap with CNT_W=4: 17 accepts → op_count reads 1.
